// File: rtl/fnn_pkg.sv
// Shared definitions for the fully connected layer blocks.
// Holds the default weight width, the signed weight type and the state
// encoding of the per-neuron weight memory streamer.
package fnn_pkg;

  // Default weight width (Q-format, signed two's complement).
  localparam int DATA_WIDTH = 16;

  typedef logic signed [DATA_WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } wmem_state_t;

endpackage : fnn_pkg

// File: rtl/w_mem_sdp_ram.sv
// Simple dual-port weight RAM: one write port, one synchronous read port
// with a single cycle of read latency. Written so synthesis can map it to
// distributed or block RAM.
//
// Ports:
//   clk    in   clock, both ports on posedge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read address
//   rdata  out  read data, valid the cycle after re
module w_mem_sdp_ram #(
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = fnn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];

  // NOTE: the array and its read register carry no reset; a reset would stop
  // the tools from mapping this onto RAM primitives, and contents are always
  // rewritten by a load burst before they are streamed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : w_mem_sdp_ram

// File: rtl/w_mem_stream.sv
// Runtime-loadable weight memory for one neuron of a fully connected layer.
// A valid/ready load burst fills the RAM from address 0; on rd_start the
// stored weights are streamed in address order through a valid/ready output
// with full backpressure. A 2-entry skid FIFO hides the RAM read latency so
// the stream sustains one weight per cycle.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   load_start in   pulse: start a load burst at address 0
//   wr_valid   in   load data valid
//   wr_ready   out  wr_data accepted this cycle
//   wr_data    in   weight to store
//   loaded     out  a full burst has been written since the last load_start
//   rd_start   in   pulse: stream weights 0..NUM_WEIGHT-1
//   out_valid  out  out_data valid
//   out_ready  in   consumer takes out_data this cycle
//   out_data   out  weight
//   out_last   out  marks the weight at index NUM_WEIGHT-1
//   busy       out  not idle, or weights still held in the output FIFO
module w_mem_stream #(
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = fnn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  loaded,
  input  logic                  rd_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  import fnn_pkg::*;

  // Pointers wrap by explicit compare, never by natural binary overflow.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHT - 1);

  wmem_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic                  all_issued;     // every address of this stream has been read
  logic                  rd_inflight;    // RAM read issued last cycle, data on ram_rdata
  logic                  inflight_last;  // that read was the final address
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Output skid FIFO, two entries.
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic [1:0]            fifo_count;
  logic                  fifo_wr_idx, fifo_rd_idx;

  logic                  start_load, start_stream;
  logic                  wr_fire, rd_issue, push, pop;
  logic [2:0]            occ_after_pop;

  // A load_start in LOAD restarts the burst, so no write is taken that cycle.
  assign wr_ready  = (state == LOAD) && !load_start;
  assign wr_fire   = wr_valid && wr_ready;

  assign out_valid = (fifo_count != 2'd0);
  // Gate the head entry so the unreset FIFO storage never shows on the port.
  assign out_data  = out_valid ? fifo_data[fifo_rd_idx] : '0;
  assign out_last  = out_valid && fifo_last[fifo_rd_idx];
  assign busy      = (state != IDLE) || out_valid;

  assign pop  = out_valid && out_ready;
  assign push = rd_inflight;

  // Count the slot freed by this cycle's pop so a steady stream issues one
  // read per cycle instead of stalling every other cycle.
  assign occ_after_pop = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_issue      = (state == STREAM) && !all_issued && (occ_after_pop < 3'd2);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement so
  // no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next   = state;
    start_load   = 1'b0;
    start_stream = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          start_load = 1'b1;
          state_next = LOAD;
        end else if (rd_start && loaded) begin
          start_stream = 1'b1;
          state_next   = STREAM;
        end
      end
      LOAD: begin
        if (load_start) begin
          start_load = 1'b1;
        end else if (wr_fire && (wptr == LAST_ADDR)) begin
          state_next = IDLE;
        end
      end
      STREAM: begin
        if (pop && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pointers and FIFO control
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wptr          <= '0;
      rptr          <= '0;
      loaded        <= 1'b0;
      all_issued    <= 1'b0;
      rd_inflight   <= 1'b0;
      inflight_last <= 1'b0;
      fifo_count    <= 2'd0;
      fifo_wr_idx   <= 1'b0;
      fifo_rd_idx   <= 1'b0;
    end else begin
      state <= state_next;

      // Load side
      if (start_load) begin
        wptr   <= '0;
        loaded <= 1'b0;
      end else if (wr_fire) begin
        if (wptr == LAST_ADDR) begin
          wptr   <= '0;
          loaded <= 1'b1;
        end else begin
          wptr <= wptr + 1'b1;
        end
      end

      // Read side
      if (start_stream) begin
        rptr       <= '0;
        all_issued <= 1'b0;
      end else if (rd_issue) begin
        if (rptr == LAST_ADDR) begin
          rptr       <= '0;
          all_issued <= 1'b1;
        end else begin
          rptr <= rptr + 1'b1;
        end
      end

      rd_inflight   <= rd_issue;
      inflight_last <= rd_issue && (rptr == LAST_ADDR);

      // Skid FIFO bookkeeping; the issue rule guarantees no overflow.
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      if (push) begin
        fifo_wr_idx <= ~fifo_wr_idx;
      end
      if (pop) begin
        fifo_rd_idx <= ~fifo_rd_idx;
      end
    end
  end

  // FIFO payload: reset flushes the FIFO through its count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wr_idx] <= ram_rdata;
      fifo_last[fifo_wr_idx] <= inflight_last;
    end
  end

  w_mem_sdp_ram #(
    .NUM_WEIGHT (NUM_WEIGHT),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

endmodule : w_mem_stream

// File: tb/tb_w_mem_stream.sv
// Self-checking bench for w_mem_stream. A behavioural model (an array of the
// weights written plus a loaded flag) predicts every streamed beat.
module tb_w_mem_stream;

  localparam int NUM = 30;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          loaded;
  logic          rd_start;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  // Reference model
  logic [DW-1:0] ref_mem [NUM];
  logic          ref_loaded;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  w_mem_stream #(
    .NUM_WEIGHT (NUM),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .loaded     (loaded),
    .rd_start   (rd_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // mode 0: 1..NUM, mode 1: 0xFF00+i, mode 2: random
  task automatic load_burst(input int n, input int mode, input bit poke_rd);
    logic [DW-1:0] w;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    ref_loaded = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       w = DW'(i + 1);
        1:       w = 16'hFF00 + DW'(i);
        default: w = DW'($urandom);
      endcase
      wr_valid = 1'b1;
      wr_data  = w;
      if (poke_rd && i == 0) rd_start = 1'b1;
      @(negedge clk);
      check("load_wr_ready", wr_ready, 1);
      check("load_no_valid", out_valid, 0);
      @(posedge clk); #1;
      rd_start   = 1'b0;
      ref_mem[i] = w;
    end
    wr_valid = 1'b0;
    if (n == NUM) ref_loaded = 1'b1;
    @(negedge clk);
    check("loaded_after_burst", loaded, ref_loaded);
    check("wr_ready_after_burst", wr_ready, (n < NUM) ? 1 : 0);
  endtask

  // Pulse rd_start and confirm nothing comes out.
  task automatic expect_no_stream(input string tag);
    int seen = 0;
    @(posedge clk); #1 rd_start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check(tag, seen, 0);
  endtask

  task automatic stream(input bit stall, input bit poke_load, input int stop_at);
    int            idx      = 0;
    int            cyc      = 0;
    int            first    = -1;
    int            last_acc = -1;
    bit            held_v   = 1'b0;
    logic [DW-1:0] held_d   = '0;
    logic          held_l   = 1'b0;
    @(posedge clk); #1 rd_start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    @(negedge clk);
    check("stream_lat_edge0", out_valid, 0);
    while (idx < stop_at && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_load) begin
        load_start = (cyc == 6);
        wr_valid   = (cyc == 6);
        wr_data    = 16'hDEAD;
      end
      @(negedge clk);
      if (poke_load && cyc == 6) check("wr_ready_in_stream", wr_ready, 0);
      if (held_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_d);
        check("stall_last", out_last, held_l);
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          check("beat_data", out_data, ref_mem[idx]);
          check("beat_last", out_last, (idx == NUM - 1) ? 1 : 0);
          idx++;
          held_v   = 1'b0;
          last_acc = cyc;
        end else begin
          held_v = 1'b1;
          held_d = out_data;
          held_l = out_last;
        end
      end
    end
    load_start = 1'b0;
    wr_valid   = 1'b0;
    check("beat_count", idx, stop_at);
    if (!stall) begin
      check("first_valid_latency", first, 2);
      check("full_throughput", last_acc - first, stop_at - 1);
    end
    if (stop_at == NUM) begin
      @(posedge clk); #1 out_ready = $urandom_range(0, 1);
      @(negedge clk);
      check("busy_after_stream", busy, 0);
      check("valid_after_stream", out_valid, 0);
      check("loaded_kept", loaded, ref_loaded);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    rd_start   = 1'b0;
    out_ready  = 1'b0;
    ref_loaded = 1'b0;
    for (int i = 0; i < NUM; i++) ref_mem[i] = '0;

    #22;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_loaded", loaded, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // rd_start with nothing loaded is ignored
    expect_no_stream("rd_before_load");

    // Sequential burst; rd_start poked during LOAD must be ignored
    load_burst(NUM, 0, 1'b1);
    stream(1'b0, 1'b0, NUM);
    stream(1'b1, 1'b0, NUM);

    // load_start during a stream is ignored
    stream(1'b0, 1'b1, NUM);

    // Partial burst, restart, full burst of 0xFF00+i
    load_burst(12, 2, 1'b0);
    load_burst(NUM, 1, 1'b0);
    stream(1'b1, 1'b0, NUM);

    // Random weights, random backpressure
    for (int r = 0; r < 3; r++) begin
      load_burst(NUM, 2, 1'b0);
      stream(1'b1, 1'b0, NUM);
    end

    // Reset mid-stream at beat 10
    stream(1'b0, 1'b0, 10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_last", out_last, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_loaded", loaded, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ref_loaded = 1'b0;
    expect_no_stream("rd_after_reset");
    load_burst(NUM, 2, 1'b0);
    stream(1'b1, 1'b0, NUM);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_w_mem_stream
